uart_rx_word: RTL and testbench
===============================

UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1250, is the number of clk cycles per bit (12 MHz / 9600 baud); legal range 16..4095.
REQ-002 Port clk  input  1  system clock, 12 MHz.
REQ-003 Port nrst  input  1  reset, asynchronous and active-low.
REQ-004 Port rx  input  1  serial line; idle high; asynchronous to clk.
REQ-005 Port byte_out  output  8  last byte received, LSB-first on the line.
REQ-006 Port byte_valid  output  1  one-cycle pulse when byte_out updates.
REQ-007 Port data_out  output  32  last assembled word; first received byte sits in [31:24].
REQ-008 Port word_valid  output  1  one-cycle pulse when data_out updates.
REQ-009 Port frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
REQ-010 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx shall pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s.
REQ-012 FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled); encoding is binary.
REQ-013 IDLE: a 1->0 transition on rx_s moves to START and clears the bit-timer.
REQ-014 START: at timer = CLKS_PER_BIT/2-1, sample rx_s; 0 -> go to DATA with the timer cleared; 1 -> false start, return to IDLE with no output.
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles; shift 8 bits LSB-first; after bit 7 go to STOP.
REQ-016 STOP: sample after CLKS_PER_BIT cycles; then always return to IDLE in the next cycle, so back-to-back frames are accepted.
REQ-017 Valid stop bit (1): the cycle after the sample, byte_out loads and byte_valid pulses; the byte goes to word slot byte_idx, and byte_idx increments (2-bit, wraps 3->0).
REQ-018 When byte_idx wraps 3->0, data_out loads the 4 collected bytes and word_valid pulses in the same cycle as byte_valid.
REQ-019 Invalid stop bit (0): frame_err pulses; the byte is discarded; byte_idx resets to 0; partial word contents are dropped.
REQ-020 Outputs not being updated hold their value; pulses never exceed one cycle.
REQ-021 There is no inter-byte timeout; partial words persist until completed, a frame error, or reset.

Reset
REQ-022 nrst low shall asynchronously force: FSM=IDLE, timer=0, bit count=0, byte_idx=0, synchronizer flops=1, byte_out=0, data_out=0, all pulses=0, busy=0.
REQ-023 Reset mid-frame abandons the frame with no output; after release, the first falling edge starts a fresh frame.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: a PARITY state between DATA and STOP samples one even-parity bit; a mismatch follows the frame-error path of REQ-019 (frame_err pulse, byte discarded, byte_idx=0), and the stop bit is still consumed.
REQ-025 Macro UART_RX_PARITY_EN undefined: the frame is 8N1, and no PARITY state or logic exists.

Structure
REQ-026 Shared package uart_pkg holds the FSM state typedef, the DATA_BITS=8 and WORD_BYTES=4 constants, and the default CLKS_PER_BIT, shared with the transmitter.
REQ-027 One sub-module, uart_rx_byte (synchronizer + FSM + byte output), shall be used; uart_rx_word adds the word assembly only.

Verification
REQ-028 Send 0x53,0x6E,0x61,0x70 (8N1, 1250 clk/bit) -> 4 byte_valid pulses; word_valid with data_out=0x536E6170 on the 4th pulse.
REQ-029 Drive rx low for 200 cycles, then high -> no byte_valid, no frame_err, busy returns low.
REQ-030 Send 0xA5 with stop bit=0, then 4 good bytes 0x11,0x22,0x33,0x44 -> frame_err pulse once, then data_out=0x11223344.
REQ-031 Assert nrst during DATA bit 4 of the 2nd byte, release it, then send 4 bytes 0xDE,0xAD,0xBE,0xEF -> data_out=0xDEADBEEF, and no output from the aborted frame.
REQ-032 With UART_RX_PARITY_EN, send 0x53 with odd parity -> frame_err and no byte_valid; with correct parity -> byte_out=0x53.
REQ-033 Send back-to-back frames with zero idle time -> every byte is received, and word_valid spacing is exactly 40*CLKS_PER_BIT cycles (8N1).

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver FSM state type (UART_RX_PARITY_EN adds the PARITY state)
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int WORD_BYTES       = 4;
    localparam int CLKS_PER_BIT_DEF = 1250;
    localparam int TIMER_W          = 12;
    localparam int BIT_CNT_W        = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronized 8-bit UART receiver FSM with byte output (UART_RX_PARITY_EN adds even parity)
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] byte_out,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 done,
    output logic                 bad
);

    localparam logic [TIMER_W-1:0]   FULL     = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0]   HALF     = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

    rx_state_t state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic rx_m, rx_s, rx_d;
`ifdef UART_RX_PARITY_EN
    logic par_err, par_err_n;
`endif

    assign busy    = state != IDLE;
    assign rx_byte = shift;

    // two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // next-state logic; bits are sampled at mid-bit, the stop sample emits done/bad
    always_comb begin
        state_n   = state;
        timer_n   = timer + 1'b1;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        done      = 1'b0;
        bad       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_n = par_err;
`endif
        case (state)
            IDLE: begin
                timer_n   = '0;
                bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                par_err_n = 1'b0;
`endif
                state_n   = (rx_d && !rx_s) ? START : IDLE;
            end
            START: if (timer == HALF) begin
                timer_n = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (timer == FULL) begin
                timer_n   = '0;
                shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                bit_cnt_n = bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                state_n   = (bit_cnt == BIT_LAST) ? PARITY : DATA;
`else
                state_n   = (bit_cnt == BIT_LAST) ? STOP : DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (timer == FULL) begin
                timer_n   = '0;
                par_err_n = ^{shift, rx_s};
                state_n   = STOP;
            end
`endif
            STOP: if (timer == FULL) begin
                timer_n = '0;
                state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                done    = rx_s && !par_err;
`else
                done    = rx_s;
`endif
                bad     = !done;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, datapath and registered one-cycle output pulses
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err    <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            byte_out   <= done ? shift : byte_out;
            byte_valid <= done;
            frame_err  <= bad;
`ifdef UART_RX_PARITY_EN
            par_err    <= par_err_n;
`endif
        end
    end

endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: UART receiver assembling four bytes into a 32-bit word, first byte in [31:24] (UART_RX_PARITY_EN adds parity)
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            rx,
    output logic [DATA_BITS-1:0]            byte_out,
    output logic                            byte_valid,
    output logic [DATA_BITS*WORD_BYTES-1:0] data_out,
    output logic                            word_valid,
    output logic                            frame_err,
    output logic                            busy
);

    logic [DATA_BITS-1:0] rx_byte;
    logic done, bad;
    logic [1:0] byte_idx;
    logic [DATA_BITS*(WORD_BYTES-1)-1:0] partial;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk       (clk),
        .nrst      (nrst),
        .rx        (rx),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .rx_byte   (rx_byte),
        .done      (done),
        .bad       (bad)
    );

    // collect bytes on the same edge the byte output loads so word_valid aligns with byte_valid
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            byte_idx   <= '0;
            partial    <= '0;
            data_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= done && byte_idx == 2'(WORD_BYTES - 1);
            if (bad) begin
                byte_idx <= '0;
                partial  <= '0;
            end else if (done) begin
                byte_idx <= byte_idx + 1'b1;
                partial  <= {partial[DATA_BITS*(WORD_BYTES-2)-1:0], rx_byte};
                if (byte_idx == 2'(WORD_BYTES - 1))
                    data_out <= {partial, rx_byte};
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed table-driven bench for uart_rx_word
module tb_uart_rx_word;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] data_out;
    logic        word_valid;
    logic        frame_err;
    logic        busy;

    uart_rx_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .rx        (rx),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .data_out  (data_out),
        .word_valid(word_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_bv = 0, n_fe = 0, n_wv = 0, dbl = 0, wv_alone = 0;
    logic bv_q = 0, fe_q = 0, wv_q = 0;
    int wv_cycs[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (byte_valid) n_bv++;
        if (frame_err) n_fe++;
        if (word_valid) begin
            n_wv++;
            wv_cycs.push_back(cyc);
        end
        if ((byte_valid && bv_q) || (frame_err && fe_q) || (word_valid && wv_q)) dbl++;
        if (word_valid && !byte_valid) wv_alone++;
        bv_q = byte_valid;
        fe_q = frame_err;
        wv_q = word_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        int          exp_bv;
        int          exp_fe;
        int          exp_wv;
        logic [7:0]  exp_byte;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int bv0, fe0, wv0;
        vecs[0] = '{8'h53, 1'b1, 1, 0, 0, 8'h53, 32'h0};
        vecs[1] = '{8'h6E, 1'b1, 1, 0, 0, 8'h6E, 32'h0};
        vecs[2] = '{8'h61, 1'b1, 1, 0, 0, 8'h61, 32'h0};
        vecs[3] = '{8'h70, 1'b1, 1, 0, 1, 8'h70, 32'h536E6170};
        vecs[4] = '{8'hAA, 1'b1, 1, 0, 0, 8'hAA, 32'h536E6170};
        vecs[5] = '{8'hA5, 1'b0, 0, 1, 0, 8'hAA, 32'h536E6170};
        vecs[6] = '{8'h11, 1'b1, 1, 0, 0, 8'h11, 32'h536E6170};
        vecs[7] = '{8'h22, 1'b1, 1, 0, 0, 8'h22, 32'h536E6170};
        vecs[8] = '{8'h33, 1'b1, 1, 0, 0, 8'h33, 32'h536E6170};
        vecs[9] = '{8'h44, 1'b1, 1, 0, 1, 8'h44, 32'h11223344};

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_byte_out", {24'b0, byte_out}, 32'h0);
        check("reset_data_out", data_out, 32'h0);
        check("reset_pulses", {29'b0, byte_valid, word_valid, frame_err}, 32'h0);
        nrst = 1'b1;
        repeat (CPB) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            bv0 = n_bv; fe0 = n_fe; wv0 = n_wv;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
            check($sformatf("vec%0d_byte_valid", i), n_bv - bv0, vecs[i].exp_bv);
            check($sformatf("vec%0d_frame_err", i), n_fe - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_word_valid", i), n_wv - wv0, vecs[i].exp_wv);
            check($sformatf("vec%0d_byte_out", i), {24'b0, byte_out}, {24'b0, vecs[i].exp_byte});
            check($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_word);
        end

        bv0 = n_bv; fe0 = n_fe;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("false_start_busy_high", {31'b0, busy}, 32'h1);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("false_start_busy_low", {31'b0, busy}, 32'h0);
        check("false_start_no_byte", n_bv - bv0, 0);
        check("false_start_no_err", n_fe - fe0, 0);

        send_frame(8'h01, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        bv0 = n_bv; fe0 = n_fe; wv0 = n_wv;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        nrst = 1'b0;
        rx = 1'b1;
        #1;
        check("abort_busy_async", {31'b0, busy}, 32'h0);
        check("abort_byte_out", {24'b0, byte_out}, 32'h0);
        check("abort_data_out", data_out, 32'h0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("abort_no_output", (n_bv - bv0) + (n_fe - fe0) + (n_wv - wv0), 0);
        bv0 = n_bv; fe0 = n_fe; wv0 = n_wv;
        send_frame(8'hDE, 1'b1, 1'b0);
        send_frame(8'hAD, 1'b1, 1'b0);
        send_frame(8'hBE, 1'b1, 1'b0);
        send_frame(8'hEF, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        check("after_abort_data_out", data_out, 32'hDEADBEEF);
        check("after_abort_bytes", n_bv - bv0, 4);
        check("after_abort_words", n_wv - wv0, 1);
        check("after_abort_err", n_fe - fe0, 0);

        bv0 = n_bv; wv0 = n_wv;
        wv_cycs.delete();
        for (int i = 0; i < 12; i++) send_frame(8'(8'h30 + i), 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("b2b_bytes", n_bv - bv0, 12);
        check("b2b_words", n_wv - wv0, 3);
        check("b2b_data_out", data_out, 32'h38393A3B);
        if (wv_cycs.size() == 3) begin
            check("b2b_gap0", wv_cycs[1] - wv_cycs[0], 40 * CPB);
            check("b2b_gap1", wv_cycs[2] - wv_cycs[1], 40 * CPB);
        end else begin
            check("b2b_word_events", wv_cycs.size(), 3);
        end

`ifdef UART_RX_PARITY_EN
        bv0 = n_bv; fe0 = n_fe;
        send_frame(8'h53, 1'b1, 1'b1);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        check("parity_bad_err", n_fe - fe0, 1);
        check("parity_bad_no_byte", n_bv - bv0, 0);
        bv0 = n_bv; fe0 = n_fe;
        send_frame(8'h53, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
        check("parity_good_byte", n_bv - bv0, 1);
        check("parity_good_err", n_fe - fe0, 0);
        check("parity_good_byte_out", {24'b0, byte_out}, 32'h53);
`endif

        check("pulse_width", dbl, 0);
        check("word_with_byte", wv_alone, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
